// File: rtl/pci_inport_pkg.sv
// Shared constants and helpers for the PIO input-word collector.
package pci_inport_pkg;

   // Status word geometry
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned SW_LSB     = 0;
   localparam int unsigned SW_W       = 18;
   localparam int unsigned KEY_LSB    = 18;
   localparam int unsigned KEY_W      = 4;
   localparam int unsigned STICKY_LSB = 22;
   localparam int unsigned STICKY_W   = 4;
   localparam int unsigned CNT_LSB    = 26;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned RSVD_LSB   = 30;
   localparam int unsigned RSVD_W     = 2;

   // Synchroniser depth used for every asynchronous input
   localparam int unsigned SYNC_STAGES = 2;

   // Bits that went from released to pressed between two debounced samples
   function automatic logic [KEY_W-1:0] rise_mask(input logic [KEY_W-1:0] cur,
                                                  input logic [KEY_W-1:0] prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/pci_inport_collector_debouncer.sv
// Single-bit synchroniser plus tick-sampled debouncer.
module input_debouncer
   import pci_inport_pkg::*;
#(
   parameter int unsigned DB_SAMPLES = 4
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic tick,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_SAMPLES-1:0]  hist_q;
   logic [DB_SAMPLES-1:0]  hist_next_c;

   // History as it will look once the current synced sample is shifted in
   assign hist_next_c = {hist_q[DB_SAMPLES-2:0], sync_q[SYNC_STAGES-1]};

   // Two-flop synchroniser for the asynchronous input
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   // Sample on tick; accept a new level only when the whole history agrees
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         hist_q <= '0;
         dout   <= 1'b0;
      end else if (tick) begin
         hist_q <= hist_next_c;
         if (&hist_next_c) begin
            dout <= 1'b1;
         end else if (~|hist_next_c) begin
            dout <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/pci_inport_collector.sv
// Collects debounced switches, key levels, sticky key presses and a press
// counter into the host-readable 32-bit PIO input word.
module pci_inport_collector
   import pci_inport_pkg::*;
#(
   parameter int unsigned NUM_SW     = 18,
   parameter int unsigned NUM_KEY    = 4,
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned DB_SAMPLES = 4
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [NUM_SW-1:0]  sw_raw,
   input  logic [NUM_KEY-1:0] key_raw_n,
   input  logic               clr_toggle,
   output logic [WORD_W-1:0]  inport_word
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0]       presc_q;
   logic                   tick_c;

   logic [NUM_SW-1:0]      sw_db;
   logic [NUM_KEY-1:0]     key_act_c;
   logic [NUM_KEY-1:0]     key_db;
   logic [KEY_W-1:0]       key_lvl_c;
   logic [KEY_W-1:0]       key_lvl_q;

   logic [SYNC_STAGES-1:0] clr_sync_q;
   logic                   clr_ref_q;
   logic                   clr_edge_c;

   logic [KEY_W-1:0]       press_c;
   logic [STICKY_W-1:0]    sticky_q;
   logic [STICKY_W-1:0]    sticky_next_c;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_next_c;

   logic [WORD_W-1:0]      word_next_c;
   logic [WORD_W-1:0]      word_q;

   // Debounce sample strobe: one cycle in every TICK_DIV
   assign tick_c = (presc_q == PRE_W'(TICK_DIV - 1));

   // Tick prescaler, counts 0..TICK_DIV-1 and wraps
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         presc_q <= '0;
      end else if (tick_c) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PRE_W'(1);
      end
   end

   // Switch debouncers
   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      input_debouncer #(
         .DB_SAMPLES (DB_SAMPLES)
      ) u_sw_db (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .tick          (tick_c),
         .din           (sw_raw[i]),
         .dout          (sw_db[i])
      );
   end

   // Keys are inverted up front so everything downstream sees 1 = pressed
   assign key_act_c = ~key_raw_n;

   // Key debouncers
   for (genvar k = 0; k < NUM_KEY; k++) begin : g_key
      input_debouncer #(
         .DB_SAMPLES (DB_SAMPLES)
      ) u_key_db (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .tick          (tick_c),
         .din           (key_act_c[k]),
         .dout          (key_db[k])
      );
   end

   assign key_lvl_c = KEY_W'(key_db);

   // Host clear request: synchronise, then compare against the last seen level
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         clr_sync_q <= '0;
         clr_ref_q  <= 1'b0;
      end else begin
         clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], clr_toggle};
         clr_ref_q  <= clr_sync_q[SYNC_STAGES-1];
      end
   end

   assign clr_edge_c = clr_sync_q[SYNC_STAGES-1] ^ clr_ref_q;

   // Press detection, sticky update (set beats clear) and press counting
   always_comb begin
      press_c       = rise_mask(key_lvl_c, key_lvl_q);
      sticky_next_c = clr_edge_c ? '0 : sticky_q;
      sticky_next_c = sticky_next_c | press_c;
      cnt_next_c    = cnt_q + CNT_W'(|press_c);
   end

   // Output word assembly; sticky and counter use their next values so an
   // event shows up one cycle after the debounced edge
   always_comb begin
      word_next_c                          = '0;
      word_next_c[SW_LSB +: SW_W]          = SW_W'(sw_db);
      word_next_c[KEY_LSB +: KEY_W]        = key_lvl_c;
      word_next_c[STICKY_LSB +: STICKY_W]  = sticky_next_c;
      word_next_c[CNT_LSB +: CNT_W]        = cnt_next_c;
      word_next_c[RSVD_LSB +: RSVD_W]      = '0;
   end

   // Event state and registered output word
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         key_lvl_q <= '0;
         sticky_q  <= '0;
         cnt_q     <= '0;
         word_q    <= '0;
      end else begin
         key_lvl_q <= key_lvl_c;
         sticky_q  <= sticky_next_c;
         cnt_q     <= cnt_next_c;
         word_q    <= word_next_c;
      end
   end

   assign inport_word = word_q;

endmodule

// File: tb/tb_pci_inport_collector.sv
// Self-checking bench for pci_inport_collector with a behavioural model.
module tb_pci_inport_collector;

   localparam int unsigned NSW  = 18;
   localparam int unsigned NKEY = 4;
   localparam int unsigned TDIV = 4;
   localparam int unsigned DBS  = 3;
   localparam int unsigned NLV  = NSW + NKEY;
   localparam int unsigned IW   = NLV + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NSW-1:0]  sw_raw = '0;
   logic [NKEY-1:0] key_raw_n = '1;
   logic            clr_toggle = 1'b0;
   logic [31:0]     inport_word;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pci_inport_collector #(
      .NUM_SW     (NSW),
      .NUM_KEY    (NKEY),
      .TICK_DIV   (TDIV),
      .DB_SAMPLES (DBS)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .sw_raw        (sw_raw),
      .key_raw_n     (key_raw_n),
      .clr_toggle    (clr_toggle),
      .inport_word   (inport_word)
   );

   // Reference model state: edge count since reset, raw input history,
   // tick-sample list, accepted levels and the event bookkeeping
   int              m_n;
   logic [IW-1:0]   m_in_q[$];
   logic [NLV-1:0]  m_samp_q[$];
   logic [NLV-1:0]  m_lvl;
   logic [NLV-1:0]  m_lvl_prev;
   logic [3:0]      m_sticky;
   logic [3:0]      m_cnt;
   logic            m_clr_ref;
   logic [31:0]     m_word;

   task automatic model_reset();
      m_n        = 0;
      m_in_q     = {};
      m_samp_q   = {};
      m_lvl      = '0;
      m_lvl_prev = '0;
      m_sticky   = '0;
      m_cnt      = '0;
      m_clr_ref  = 1'b0;
      m_word     = '0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic model_step();
      logic [IW-1:0] syn;
      logic [3:0]    press;
      logic          all1;
      logic          all0;
      m_in_q.push_back({clr_toggle, ~key_raw_n, sw_raw});
      if (m_in_q.size() > 3) void'(m_in_q.pop_front());
      syn = (m_in_q.size() == 3) ? m_in_q[0] : '0;
      press = m_lvl[NSW +: 4] & ~m_lvl_prev[NSW +: 4];
      if (syn[IW-1] != m_clr_ref) m_sticky = '0;
      m_clr_ref = syn[IW-1];
      m_sticky  = m_sticky | press;
      if (press != 4'b0) m_cnt = m_cnt + 4'd1;
      m_word = {2'b00, m_cnt, m_sticky, m_lvl[NSW +: 4], m_lvl[NSW-1:0]};
      m_lvl_prev = m_lvl;
      if ((m_n % TDIV) == (TDIV - 1)) begin
         m_samp_q.push_back(syn[NLV-1:0]);
         if (m_samp_q.size() > DBS) void'(m_samp_q.pop_front());
         for (int b = 0; b < NLV; b++) begin
            all1 = (m_samp_q.size() == DBS);
            all0 = 1'b1;
            foreach (m_samp_q[s]) begin
               if (m_samp_q[s][b]) all0 = 1'b0;
               else                all1 = 1'b0;
            end
            if (all1)      m_lvl[b] = 1'b1;
            else if (all0) m_lvl[b] = 1'b0;
         end
      end
      m_n++;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sw_raw = '0; key_raw_n = '1; clr_toggle = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (inport_word !== 32'h0) begin
         errors++; $display("FAIL reset_init: inport_word=%h expected %h", inport_word, 32'h0);
      end
      @(negedge clk); rst_n = 1'b1; model_reset();
      sw_raw = 18'h155AA;
      repeat (25) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL reset_run: inport_word=%h expected %h", inport_word, m_word);
         end
      end
      checks++;
      if (inport_word[17:0] !== 18'h155AA) begin
         errors++; $display("FAIL reset_pre: sw field=%h expected %h", inport_word[17:0], 18'h155AA);
      end
      #3; rst_n = 1'b0; sw_raw = '0; key_raw_n = '1;
      #1; checks++;
      if (inport_word !== 32'h0) begin
         errors++; $display("FAIL reset_async: inport_word=%h expected %h", inport_word, 32'h0);
      end
      repeat (5) begin
         @(posedge clk); #1; checks++;
         if (inport_word !== 32'h0) begin
            errors++; $display("FAIL reset_hold: inport_word=%h expected %h", inport_word, 32'h0);
         end
      end
      @(negedge clk); rst_n = 1'b1; model_reset();
   endtask

   task automatic test_switch();
      bit found = 1'b0;
      repeat (6) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL switch_idle: inport_word=%h expected %h", inport_word, m_word);
         end
      end
      sw_raw = 18'h2A5A5;
      for (int c = 0; c < 20; c++) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL switch_model: inport_word=%h expected %h", inport_word, m_word);
         end
         if (c < 19 && inport_word[17:0] === 18'h2A5A5) found = 1'b1;
         checks++;
         if (inport_word[31:18] !== 14'h0) begin
            errors++; $display("FAIL switch_upper: [31:18]=%h expected %h", inport_word[31:18], 14'h0);
         end
      end
      checks++;
      if (!found || inport_word[17:0] !== 18'h2A5A5) begin
         errors++; $display("FAIL switch_latency: sw field=%h expected %h within 19 cycles", inport_word[17:0], 18'h2A5A5);
      end
   endtask

   task automatic test_glitch();
      key_raw_n[1] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (c == 5) key_raw_n[1] = 1'b1;
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL glitch_model: inport_word=%h expected %h", inport_word, m_word);
         end
         checks++;
         if ({inport_word[19], inport_word[23], inport_word[29:26]} !== 6'b0) begin
            errors++; $display("FAIL glitch_bits: key1=%b sticky1=%b cnt=%h expected all 0",
                               inport_word[19], inport_word[23], inport_word[29:26]);
         end
      end
   endtask

   task automatic test_press();
      bit seen_high = 1'b0;
      key_raw_n[2] = 1'b0;
      for (int c = 0; c < 55; c++) begin
         if (c == 30) key_raw_n[2] = 1'b1;
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL press_model: inport_word=%h expected %h", inport_word, m_word);
         end
         if (c < 30 && inport_word[20] === 1'b1) seen_high = 1'b1;
      end
      checks++;
      if (seen_high !== 1'b1 || inport_word[20] !== 1'b0) begin
         errors++; $display("FAIL press_level: rose=%b final=%b expected rose=1 final=0", seen_high, inport_word[20]);
      end
      checks++;
      if (inport_word[24] !== 1'b1 || inport_word[29:26] !== 4'd1) begin
         errors++; $display("FAIL press_sticky: sticky2=%b cnt=%h expected 1 and 1", inport_word[24], inport_word[29:26]);
      end
   endtask

   task automatic test_clear();
      int p;
      int t;
      int l;
      clr_toggle = ~clr_toggle;
      for (int c = 1; c <= 3; c++) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL clear_model: inport_word=%h expected %h", inport_word, m_word);
         end
         if (c == 2) begin
            checks++;
            if (inport_word[25:22] !== 4'b0100) begin
               errors++; $display("FAIL clear_early: sticky=%b expected %b", inport_word[25:22], 4'b0100);
            end
         end
      end
      checks++;
      if (inport_word[25:22] !== 4'b0000) begin
         errors++; $display("FAIL clear_3cyc: sticky=%b expected %b", inport_word[25:22], 4'b0000);
      end
      // Set sticky1 so the collision has another bit to clear
      key_raw_n[1] = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c == 20) key_raw_n[1] = 1'b1;
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL clear_setup: inport_word=%h expected %h", inport_word, m_word);
         end
      end
      // Key0 press at edge p is accepted on the third tick after it is synced;
      // the event fires one edge later, and the clear lands on that same edge
      p = m_n;
      key_raw_n[0] = 1'b0;
      t = p + 2;
      while ((t % TDIV) != (TDIV - 1)) t++;
      l = t + (DBS - 1) * TDIV;
      while (m_n < l - 1) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL collide_model: inport_word=%h expected %h", inport_word, m_word);
         end
      end
      clr_toggle = ~clr_toggle;
      while (m_n < l + 2) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL collide_model: inport_word=%h expected %h", inport_word, m_word);
         end
      end
      checks++;
      if (inport_word[25:22] !== 4'b0001) begin
         errors++; $display("FAIL collide_sticky: sticky=%b expected %b", inport_word[25:22], 4'b0001);
      end
      key_raw_n[0] = 1'b1;
      repeat (20) begin
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL collide_release: inport_word=%h expected %h", inport_word, m_word);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk); rst_n = 1'b0; sw_raw = '0; key_raw_n = '1;
      @(negedge clk); rst_n = 1'b1; model_reset();
      for (int n = 1; n <= 16; n++) begin
         key_raw_n[3] = 1'b0;
         for (int c = 0; c < 36; c++) begin
            if (c == 18) key_raw_n[3] = 1'b1;
            step(); checks++;
            if (inport_word !== m_word) begin
               errors++; $display("FAIL wrap_model: inport_word=%h expected %h", inport_word, m_word);
            end
         end
         if (n == 15) begin
            checks++;
            if (inport_word[29:26] !== 4'hF) begin
               errors++; $display("FAIL wrap_15: cnt=%h expected %h", inport_word[29:26], 4'hF);
            end
         end
      end
      checks++;
      if (inport_word[29:26] !== 4'h0 || inport_word[25] !== 1'b1) begin
         errors++; $display("FAIL wrap_16: cnt=%h sticky3=%b expected 0 and 1", inport_word[29:26], inport_word[25]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 19) == 0) sw_raw = NSW'($urandom);
         for (int k = 0; k < NKEY; k++) begin
            if ($urandom_range(0, 9) == 0) key_raw_n[k] = ~key_raw_n[k];
         end
         if ($urandom_range(0, 49) == 0) clr_toggle = ~clr_toggle;
         step(); checks++;
         if (inport_word !== m_word) begin
            errors++; $display("FAIL random: cycle %0d inport_word=%h expected %h", i, inport_word, m_word);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_switch();
      test_glitch();
      test_press();
      test_clear();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
